// File: rtl/game_pkg.sv
// Shared types and constants for the match scoreboard: counter "who" codes,
// scoreboard FSM states and the completed-match record layout.
package game_pkg;

  localparam int unsigned TALLY_W_DEF     = 4;
  localparam int unsigned ID_W_DEF        = 8;
  localparam int unsigned MATCH_GAMES_DEF = 3;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_A    = 2'b10;
  localparam logic [1:0] WHO_B    = 2'b01;

  typedef enum logic {
    PLAY   = 1'b0,
    RECORD = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0]    match_id;
    logic                   champ;
    logic [TALLY_W_DEF-1:0] wins_a;
    logic [TALLY_W_DEF-1:0] wins_b;
  } game_rec_t;

  localparam int unsigned REC_W_DEF = $bits(game_rec_t);

endpackage

// File: rtl/game_match_scoreboard_fifo.sv
// First-word-fall-through synchronous FIFO holding completed match records.
module score_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    do_pop   = pop_i && !empty_q;
    do_push  = push_i && (!full_q || do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    empty_d  = (count_d == '0);
    full_d   = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/game_match_scoreboard.sv
// Tallies games reported by the multi-mode counter, declares matches and
// queues one record per completed match for the host.
module game_match_scoreboard
  import game_pkg::*;
#(
  parameter int unsigned TALLY_W     = TALLY_W_DEF,
  parameter int unsigned MATCH_GAMES = MATCH_GAMES_DEF,
  parameter int unsigned ID_W        = ID_W_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        win_lvl,
  input  logic                        lose_lvl,
  input  logic                        gameover,
  input  logic [1:0]                  who,
  output logic                        rec_valid,
  input  logic                        rec_ready,
  output logic [ID_W+2*TALLY_W:0]     rec_data,
  output logic [TALLY_W-1:0]          wins_a,
  output logic [TALLY_W-1:0]          wins_b,
  output logic [TALLY_W-1:0]          win_hits,
  output logic [TALLY_W-1:0]          lose_hits,
  output logic                        proto_err,
  output logic                        overflow
);

  localparam int unsigned REC_W = ID_W + 1 + 2 * TALLY_W;
  localparam logic [TALLY_W-1:0] HIT_MAX = {TALLY_W{1'b1}};
  localparam logic [TALLY_W-1:0] GOAL    = TALLY_W'(MATCH_GAMES);

  sb_state_e         state_q, state_d;
  logic              win_lvl_q, lose_lvl_q;
  logic [TALLY_W-1:0] win_hits_q, win_hits_d;
  logic [TALLY_W-1:0] lose_hits_q, lose_hits_d;
  logic [TALLY_W-1:0] wins_a_q, wins_a_d;
  logic [TALLY_W-1:0] wins_b_q, wins_b_d;
  logic [TALLY_W-1:0] fin_a_q, fin_a_d;
  logic [TALLY_W-1:0] fin_b_q, fin_b_d;
  logic              champ_q, champ_d;
  logic [ID_W-1:0]   match_id_q, match_id_d;
  logic              proto_err_q, proto_err_d;
  logic              overflow_q, overflow_d;

  logic              game_a, game_b, in_rec, done;
  logic [TALLY_W-1:0] base_a, base_b, new_a, new_b;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REC_W-1:0]  fifo_wdata;

  // Next-state: a RECORD cycle starts the next match from zero, so a game
  // arriving then becomes that match's first point instead of being lost.
  always_comb begin
    state_d     = PLAY;
    champ_d     = champ_q;
    fin_a_d     = fin_a_q;
    fin_b_d     = fin_b_q;
    win_hits_d  = win_hits_q;
    lose_hits_d = lose_hits_q;

    game_a = gameover && (who == WHO_A);
    game_b = gameover && (who == WHO_B);
    in_rec = (state_q == RECORD);

    base_a = in_rec ? '0 : wins_a_q;
    base_b = in_rec ? '0 : wins_b_q;
    new_a  = base_a + TALLY_W'(game_a);
    new_b  = base_b + TALLY_W'(game_b);
    done   = (new_a == GOAL) || (new_b == GOAL);

    wins_a_d = new_a;
    wins_b_d = new_b;
    if (done) begin
      state_d = RECORD;
      champ_d = (new_a == GOAL);
      fin_a_d = new_a;
      fin_b_d = new_b;
    end

    fifo_pop   = !fifo_empty && rec_ready;
    fifo_push  = in_rec && (!fifo_full || fifo_pop);
    fifo_wdata = {match_id_q, champ_q, fin_a_q, fin_b_q};
    match_id_d = match_id_q + ID_W'(in_rec);
    overflow_d = overflow_q || (in_rec && !fifo_push);
    proto_err_d = proto_err_q || (gameover && !game_a && !game_b);

    if (win_lvl && !win_lvl_q && (win_hits_q != HIT_MAX)) begin
      win_hits_d = win_hits_q + TALLY_W'(1);
    end
    if (lose_lvl && !lose_lvl_q && (lose_hits_q != HIT_MAX)) begin
      lose_hits_d = lose_hits_q + TALLY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PLAY;
      win_lvl_q   <= 1'b0;
      lose_lvl_q  <= 1'b0;
      win_hits_q  <= '0;
      lose_hits_q <= '0;
      wins_a_q    <= '0;
      wins_b_q    <= '0;
      fin_a_q     <= '0;
      fin_b_q     <= '0;
      champ_q     <= 1'b0;
      match_id_q  <= '0;
      proto_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_lvl_q   <= win_lvl;
      lose_lvl_q  <= lose_lvl;
      win_hits_q  <= win_hits_d;
      lose_hits_q <= lose_hits_d;
      wins_a_q    <= wins_a_d;
      wins_b_q    <= wins_b_d;
      fin_a_q     <= fin_a_d;
      fin_b_q     <= fin_b_d;
      champ_q     <= champ_d;
      match_id_q  <= match_id_d;
      proto_err_q <= proto_err_d;
      overflow_q  <= overflow_d;
    end
  end

  score_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (rec_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_valid = !fifo_empty;
  assign wins_a    = wins_a_q;
  assign wins_b    = wins_b_q;
  assign win_hits  = win_hits_q;
  assign lose_hits = lose_hits_q;
  assign proto_err = proto_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_game_match_scoreboard.sv
// Directed bench for game_match_scoreboard with a queue of expected records.
module tb_game_match_scoreboard;
  import game_pkg::*;

  localparam int unsigned REC_W = REC_W_DEF;
  localparam int          DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             win_lvl, lose_lvl, gameover, rec_ready;
  logic [1:0]       who;
  logic             rec_valid, proto_err, overflow;
  logic [REC_W-1:0] rec_data;
  logic [3:0]       wins_a, wins_b, win_hits, lose_hits;

  int checks = 0;
  int errors = 0;

  logic [REC_W-1:0] exp_q [$];
  int ma, mb, exp_id;
  bit exp_perr, exp_ovf, allow_pop;

  always #5 clk = ~clk;

  game_match_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .win_lvl   (win_lvl),
    .lose_lvl  (lose_lvl),
    .gameover  (gameover),
    .who       (who),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .wins_a    (wins_a),
    .wins_b    (wins_b),
    .win_hits  (win_hits),
    .lose_hits (lose_hits),
    .proto_err (proto_err),
    .overflow  (overflow)
  );

  function automatic logic [REC_W-1:0] mk(input int id, input bit ch, input int a, input int b);
    game_rec_t r;
    r.match_id = 8'(id);
    r.champ    = ch;
    r.wins_a   = 4'(a);
    r.wins_b   = 4'(b);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ma = 0; mb = 0; exp_id = 0;
    exp_perr = 1'b0; exp_ovf = 1'b0; allow_pop = 1'b0;
    exp_q.delete();
  endtask

  // One-cycle gameover pulse; the model tallies it and queues any finished match.
  task automatic send(input logic [1:0] w);
    gameover = 1'b1;
    who      = w;
    tick();
    gameover = 1'b0;
    who      = 2'b00;
    if (w == WHO_A) ma++;
    else if (w == WHO_B) mb++;
    else exp_perr = 1'b1;
    chk("wins_a", wins_a, ma);
    chk("wins_b", wins_b, mb);
    chk("proto_err", proto_err, exp_perr);
    if (ma == 3 || mb == 3) begin
      if (exp_q.size() < DEPTH || allow_pop) exp_q.push_back(mk(exp_id, ma == 3, ma, mb));
      else exp_ovf = 1'b1;
      exp_id = (exp_id + 1) % 256;
      ma = 0;
      mb = 0;
    end
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0) break;
      if (rec_valid) chk("rec_data_pop", rec_data, exp_q.pop_front());
      tick();
    end
    rec_ready = 1'b0;
    chk("drain_timeout", exp_q.size(), 0);
    chk("rec_valid_empty", rec_valid, 0);
  endtask

  initial begin
    rst = 1'b1; win_lvl = 1'b1; lose_lvl = 1'b0; gameover = 1'b0;
    who = 2'b00; rec_ready = 1'b0;
    ma = 0; mb = 0; exp_id = 0; exp_perr = 1'b0; exp_ovf = 1'b0; allow_pop = 1'b0;

    // Reset with win_lvl already high
    tick();
    tick();
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_rec_data", rec_data, 0);
    chk("rst_wins_a", wins_a, 0);
    chk("rst_wins_b", wins_b, 0);
    chk("rst_win_hits", win_hits, 0);
    chk("rst_lose_hits", lose_hits, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();
    chk("win_hits_first", win_hits, 1);
    repeat (3) tick();
    chk("win_hits_hold", win_hits, 1);
    win_lvl = 1'b0;
    tick();
    win_lvl = 1'b1;
    tick();
    chk("win_hits_second", win_hits, 2);
    win_lvl = 1'b0;
    repeat (20) begin
      lose_lvl = 1'b1; tick();
      lose_lvl = 1'b0; tick();
    end
    chk("lose_hits_sat", lose_hits, 15);

    // A takes the match 3-0, record appears two cycles after the last game
    do_reset();
    send(WHO_A); repeat (4) tick();
    send(WHO_A); repeat (4) tick();
    send(WHO_A);
    chk("rec_valid_early", rec_valid, 0);
    tick();
    chk("rec_valid_lat2", rec_valid, 1);
    chk("rec_data_a", rec_data, exp_q[0]);
    chk("wins_a_cleared", wins_a, 0);
    repeat (3) tick();
    chk("rec_data_hold", rec_data, exp_q[0]);
    drain();

    // Two identical mixed matches, B wins 3-2, ids 0 then 1
    do_reset();
    repeat (2) begin
      send(WHO_B); tick(); send(WHO_A); tick(); send(WHO_B); tick();
      send(WHO_A); tick(); send(WHO_B); repeat (2) tick();
    end
    drain();

    // Back-to-back: next game arrives during RECORD
    do_reset();
    send(WHO_A); send(WHO_A); send(WHO_A); send(WHO_A);
    tick();
    chk("b2b_wins_a", wins_a, 1);
    chk("b2b_wins_b", wins_b, 0);
    send(WHO_A); send(WHO_A);
    repeat (2) tick();
    drain();

    // Overflow: five matches into a four-entry FIFO with no host reads
    do_reset();
    repeat (5) begin
      send(WHO_A); send(WHO_A); send(WHO_A); repeat (2) tick();
    end
    chk("overflow_set", overflow, exp_ovf);
    chk("overflow_model", exp_ovf, 1);
    drain();
    chk("overflow_sticky", overflow, 1);

    // Same, but the host pops in the fifth RECORD cycle
    do_reset();
    repeat (4) begin
      send(WHO_A); send(WHO_A); send(WHO_A); repeat (2) tick();
    end
    send(WHO_A); send(WHO_A);
    allow_pop = 1'b1;
    send(WHO_A);
    allow_pop = 1'b0;
    rec_ready = 1'b1;
    chk("rec_valid_full", rec_valid, 1);
    chk("rec_data_pop_rec", rec_data, exp_q.pop_front());
    tick();
    rec_ready = 1'b0;
    chk("no_overflow", overflow, exp_ovf);
    drain();

    // Protocol errors leave tallies untouched and stick until reset
    do_reset();
    send(WHO_A);
    send(WHO_NONE);
    send(2'b11);
    repeat (3) tick();
    chk("perr_sticky", proto_err, 1);
    chk("perr_wins_a", wins_a, 1);
    do_reset();
    chk("perr_cleared", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_match_scoreboard.md
Name: game_match_scoreboard

Overview:
- Downstream consumer of the multi-mode counter.
- Edge-detects the counter's winner/loser levels and its one-cycle GAMEOVER/who report, tallies games per side and declares a match once a side reaches MATCH_GAMES wins.
- Each completed match is pushed as a record into a small FIFO, drained by the host over a valid/ready handshake.

Parameters:
- TALLY_W, 4, width of per-side game tallies and hit counters.
- MATCH_GAMES, 3, games a side must win to take the match (1..2^TALLY_W-1).
- ID_W, 8, width of match sequence number.
- FIFO_DEPTH, 4, record FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- win_lvl  in  1  counter winner output (count at max).
- lose_lvl  in  1  counter loser output (count at zero).
- gameover  in  1  counter GAMEOVER pulse.
- who  in  2  counter who; 2'b10 = winner side (A) took the game, 2'b01 = loser side (B).
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  host accepts head.
- rec_data  out  ID_W+1+2*TALLY_W  {match_id, champ (1=A,0=B), wins_a, wins_b}.
- wins_a  out  TALLY_W  live games won by A in the current match.
- wins_b  out  TALLY_W  live games won by B in the current match.
- win_hits  out  TALLY_W  rising edges of win_lvl; saturating.
- lose_hits  out  TALLY_W  rising edges of lose_lvl; saturating.
- proto_err  out  1  sticky: gameover seen with who not in {10,01}.
- overflow  out  1  sticky: record dropped because the FIFO was full.

Behaviour:
- Reset (sync):
  - All outputs 0, FIFO empty, match_id=0, state PLAY.
  - Edge-detect registers cleared to 0, so a level already high at reset release counts as an edge on the next cycle.
- Hit counters:
  - Registered input delays feed the edge detectors; win_hits increments when win_lvl & !win_lvl_d, likewise lose_hits.
  - Saturate at 2^TALLY_W-1; never wrap.
  - Cleared only by rst.
- Game accept, valid in any state:
  - On a cycle with gameover=1, who=10 increments wins_a and who=01 increments wins_b; the new value is visible on the next cycle.
  - who=00/11 sets proto_err; tallies are unchanged.
  - gameover high on consecutive cycles counts once per cycle; no edge detection, since the counter guarantees one-cycle pulses.
- FSM states: PLAY, RECORD.
  - PLAY -> RECORD on the cycle a tally update makes wins_a or wins_b == MATCH_GAMES. That cycle registers champ and the final tallies into a record latch.
  - RECORD, exactly 1 cycle:
    - If the FIFO is not full (a pop in the same cycle counts as space), push {match_id, champ, final wins_a, final wins_b}.
    - Otherwise set overflow and drop the record.
    - Either way: match_id += 1 (wraps modulo 2^ID_W), wins_a/wins_b cleared, -> PLAY.
  - A gameover arriving in RECORD is the first game of the next match: tallies are set to 1/0 or 0/1 instead of cleared.
- FIFO:
  - First-word-fall-through; rec_data is valid whenever rec_valid=1.
  - Pop when rec_valid & rec_ready.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty is ignored.
  - rec_data holds stable while rec_valid=1 and rec_ready=0.
- Latency:
  - gameover that completes a match -> record visible on rec_valid 2 cycles later, if the FIFO was empty.
- Arithmetic:
  - Tallies cannot exceed MATCH_GAMES, because reaching it forces RECORD.
  - All adds are unsigned, same-width.

Decomposition:
- Package game_pkg:
  - WHO_NONE=2'b00, WHO_A=2'b10, WHO_B=2'b01.
  - Scoreboard state enum {PLAY, RECORD}.
  - Record struct typedef {match_id, champ, wins_a, wins_b}, parameterised via localparams.
- Sub-module score_fifo: parameterised FWFT synchronous FIFO (WIDTH, DEPTH) with full/empty flags. All match logic stays in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with win_lvl=1 -> all outputs 0. After release, win_hits=1 one cycle later; win_hits is unchanged while win_lvl stays high.
- A takes match: 3 gameover pulses with who=10, spaced 5 cycles, rec_ready=0.
  - Expect wins_a to step 1,2,3.
  - Expect rec_valid=1 with rec_data={0,1,3,0} exactly 2 cycles after the third pulse.
  - Expect wins_a=0 afterwards.
- Mixed match: who sequence 01,10,01,10,01 -> record {0,0,2,3}. A second identical match gives match_id=1.
- Back-to-back: match-completing pulse, then the next pulse (who=10) lands in RECORD -> wins_a=1, wins_b=0 after RECORD; no game lost.
- Overflow: rec_ready=0, complete 5 matches with FIFO_DEPTH=4 -> overflow=1 after the 5th; popping yields match_ids 0..3 in order. Repeat with rec_ready=1 asserted in the 5th match's RECORD cycle -> no overflow, ids 1..4 remain.
- Protocol error: gameover=1 with who=00, then who=11 -> proto_err=1 sticky, wins_a/wins_b unchanged; cleared only by rst.
